// File: rtl/rf68000_nic_arb.sv
// Round-robin arbiter sharing one NIC slave port among NREQ local bus masters.
// The grant is held for a whole bus cycle. An idle gap separates owners. A watchdog aborts stalled cycles.
module rf68000_nic_arb #(
  parameter int NREQ = 4,
  parameter int TMO  = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      r_cyc_i,
  input  logic [NREQ-1:0]      r_stb_i,
  input  logic [NREQ-1:0]      r_we_i,
  input  logic [NREQ*3-1:0]    r_cti_i,
  input  logic [NREQ*4-1:0]    r_sel_i,
  input  logic [NREQ*32-1:0]   r_adr_i,
  input  logic [NREQ*32-1:0]   r_dat_i,
  output logic [NREQ-1:0]      r_ack_o,
  output logic [NREQ-1:0]      r_rty_o,
  output logic [NREQ-1:0]      r_err_o,
  output logic [31:0]          r_dat_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [2:0]           s_cti_o,
  output logic [3:0]           s_sel_o,
  output logic [31:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  input  logic                 s_ack_i,
  input  logic                 s_rty_i,
  input  logic [31:0]          s_dat_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 busy_o
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW1 = PW + 1;
  localparam int TW  = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [NREQ-1:0] gnt_n;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_n;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_n;
  logic [PW-1:0]   own;
  logic [PW-1:0]   own_next;
  logic [PW-1:0]   pick;
  logic            pick_ok;
  logic [NREQ-1:0] req;
  logic [PW1-1:0]  cand;

  logic [2:0]  cti_a [NREQ];
  logic [3:0]  sel_a [NREQ];
  logic [31:0] adr_a [NREQ];
  logic [31:0] dat_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign cti_a[g] = r_cti_i[g*3 +: 3];
    assign sel_a[g] = r_sel_i[g*4 +: 4];
    assign adr_a[g] = r_adr_i[g*32 +: 32];
    assign dat_a[g] = r_dat_i[g*32 +: 32];
  end

  assign req      = r_cyc_i & r_stb_i;
  assign own_next = (own == PW'(NREQ - 1)) ? '0 : own + PW'(1);
  assign busy_o   = (state != ST_IDLE);

  // Binary index of the current one-hot grant.
  always_comb begin
    own = '0;
    for (int i = 0; i < NREQ; i++) begin
      own = gnt_o[i] ? PW'(i) : own;
    end
  end

  // Scan farthest-to-nearest from ptr so the closest requester at or after ptr wins.
  always_comb begin
    pick    = '0;
    cand    = '0;
    pick_ok = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + PW1'(i);
      cand = (cand >= PW1'(NREQ)) ? cand - PW1'(NREQ) : cand;
      pick = req[cand[PW-1:0]] ? cand[PW-1:0] : pick;
    end
  end

  // State, grant, pointer and watchdog registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      gnt_o <= '0;
      ptr   <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      gnt_o <= gnt_n;
      ptr   <= ptr_n;
      timer <= timer_n;
    end
  end

  // Next-state logic; a NIC response in the timeout clock beats the watchdog.
  always_comb begin
    state_n = state;
    gnt_n   = gnt_o;
    ptr_n   = ptr;
    timer_n = timer;
    case (state)
      ST_IDLE: begin
        if (pick_ok) begin
          gnt_n       = '0;
          gnt_n[pick] = 1'b1;
          timer_n     = '0;
          state_n     = ST_BUSY;
        end else begin
          gnt_n = '0;
        end
      end
      ST_BUSY: begin
        if (!r_cyc_i[own]) begin
          ptr_n   = own_next;
          gnt_n   = '0;
          timer_n = '0;
          state_n = ST_GAP;
        end else if (s_ack_i || s_rty_i) begin
          timer_n = '0;
        end else if (timer == TW'(TMO)) begin
          state_n = ST_ERR;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      ST_ERR: begin
        if (!r_cyc_i[own]) begin
          ptr_n   = own_next;
          gnt_n   = '0;
          timer_n = '0;
          state_n = ST_GAP;
        end else begin
          state_n = ST_ERR;
        end
      end
      ST_GAP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // NIC-side mux and owner-only response routing; everything is zero unless a cycle is live.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_cti_o = 3'b000;
    s_sel_o = 4'h0;
    s_adr_o = 32'h0;
    s_dat_o = 32'h0;
    r_ack_o = '0;
    r_rty_o = '0;
    r_err_o = '0;
    r_dat_o = 32'h0;
    case (state)
      ST_BUSY: begin
        s_cyc_o      = r_cyc_i[own];
        s_stb_o      = r_stb_i[own];
        s_we_o       = r_we_i[own];
        s_cti_o      = cti_a[own];
        s_sel_o      = sel_a[own];
        s_adr_o      = adr_a[own];
        s_dat_o      = dat_a[own];
        r_ack_o[own] = s_ack_i;
        r_rty_o[own] = s_rty_i;
        r_dat_o      = s_dat_i;
      end
      ST_ERR: begin
        r_err_o[own] = r_cyc_i[own];
      end
      default: begin
        r_dat_o = 32'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_rf68000_nic_arb.sv
// Directed bench for rf68000_nic_arb: the stimulus queues expected grants, responses and errors.
// A negedge monitor pops the queues and compares them whenever the DUT presents one.
module tb_rf68000_nic_arb;
  localparam int NREQ = 4;
  localparam int TMO  = 15;

  typedef struct packed {
    logic [3:0]  ack;
    logic [3:0]  rty;
    logic [31:0] dat;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_i;
  logic [NREQ-1:0]     cyc, stb, we;
  logic [NREQ*3-1:0]   cti;
  logic [NREQ*4-1:0]   sel;
  logic [NREQ*32-1:0]  adr, wdat;
  logic [NREQ-1:0]     r_ack_o, r_rty_o, r_err_o, gnt_o;
  logic [31:0]         r_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic                s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_rty_i, busy_o;
  logic [2:0]          s_cti_o;
  logic [3:0]          s_sel_o;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_gnt [$];
  resp_t      exp_resp [$];
  logic [3:0] exp_err [$];

  rf68000_nic_arb #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .r_cyc_i(cyc), .r_stb_i(stb), .r_we_i(we), .r_cti_i(cti), .r_sel_i(sel),
    .r_adr_i(adr), .r_dat_i(wdat),
    .r_ack_o(r_ack_o), .r_rty_o(r_rty_o), .r_err_o(r_err_o), .r_dat_o(r_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cti_o(s_cti_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
    .gnt_o(gnt_o), .busy_o(busy_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_req(input int i, input logic on, input logic [31:0] a);
    cyc[i]          = on;
    stb[i]          = on;
    adr[i*32 +: 32] = a;
    sel[i*4 +: 4]   = on ? 4'hF : 4'h0;
  endtask

  // Returns at the first negedge that shows a non-zero grant.
  task automatic wait_gnt();
    int n;
    n = 0;
    @(negedge clk);
    while (gnt_o == 4'b0000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (gnt_o == 4'b0000) chk("gnt_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: compare every new grant, every response pulse and every error onset.
  initial begin
    logic [3:0] gnt_prev, err_prev, eg;
    resp_t er;
    gnt_prev = 4'b0000;
    err_prev = 4'b0000;
    forever begin
      @(negedge clk);
      if (gnt_o != 4'b0000 && gnt_o != gnt_prev) begin
        if (exp_gnt.size() == 0) chk("unexpected_gnt", 64'(gnt_o), 64'd0);
        else begin
          eg = exp_gnt.pop_front();
          chk("gnt", 64'(gnt_o), 64'(eg));
        end
      end
      if ((r_ack_o | r_rty_o) != 4'b0000) begin
        if (exp_resp.size() == 0) chk("unexpected_resp", 64'({r_ack_o, r_rty_o}), 64'd0);
        else begin
          er = exp_resp.pop_front();
          chk("resp", 64'({r_ack_o, r_rty_o, r_dat_o}), 64'(er));
        end
      end
      if (r_err_o != 4'b0000 && err_prev == 4'b0000) begin
        if (exp_err.size() == 0) chk("unexpected_err", 64'(r_err_o), 64'd0);
        else begin
          eg = exp_err.pop_front();
          chk("err", 64'(r_err_o), 64'(eg));
        end
      end
      gnt_prev = gnt_o;
      err_prev = r_err_o;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int o;
    rst_i = 1'b1;
    cyc = '0; stb = '0; we = '0; cti = '0; sel = '0; adr = '0; wdat = '0;
    s_ack_i = 1'b0; s_rty_i = 1'b0; s_dat_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_resp", 64'({r_ack_o, r_rty_o, r_err_o}), 64'd0);
    @(posedge clk); #1 rst_i = 1'b0;

    // Single requester read
    set_req(1, 1'b1, 32'hC010_0010);
    exp_gnt.push_back(4'b0010);
    wait_gnt();
    chk("t1_gnt", 64'(gnt_o), 64'h2);
    chk("t1_cyc", 64'(s_cyc_o), 64'd1);
    chk("t1_adr", 64'(s_adr_o), 64'hC010_0010);
    @(posedge clk); #1;
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    exp_resp.push_back('{4'b0010, 4'b0000, 32'h1234_5678});
    @(posedge clk); #1;
    s_ack_i = 1'b0; s_dat_i = 32'h0;
    set_req(1, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_gap_cyc", 64'(s_cyc_o), 64'd0);
    chk("t1_gap_gnt", 64'(gnt_o), 64'd0);
    chk("t1_gap_busy", 64'(busy_o), 64'd1);
    @(negedge clk);
    chk("t1_idle_busy", 64'(busy_o), 64'd0);

    // Round robin from ptr=0, cyc dropped in the ack clock
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'h1000_0000 + 32'(i));
    for (int k = 0; k < 5; k++) exp_gnt.push_back(4'b0001 << (k % 4));
    for (int k = 0; k < 5; k++) begin
      o = k % 4;
      wait_gnt();
      chk("t2_adr", 64'(s_adr_o), 64'(32'h1000_0000 + 32'(o)));
      @(posedge clk); #1;
      s_ack_i = 1'b1; s_dat_i = 32'hA000_0000 + 32'(k);
      exp_resp.push_back('{4'b0001 << o, 4'b0000, 32'hA000_0000 + 32'(k)});
      if (k == 4) for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h0);
      else set_req(o, 1'b0, 32'h0);
      @(posedge clk); #1;
      s_ack_i = 1'b0; s_dat_i = 32'h0;
      if (k < 4) set_req(o, 1'b1, 32'h1000_0000 + 32'(o));
    end

    // Retry hold: ptr=1, requesters 2 and 3 compete
    set_req(2, 1'b1, 32'h2000_0002);
    we[2] = 1'b1; wdat[2*32 +: 32] = 32'hDEAD_0002;
    set_req(3, 1'b1, 32'h2000_0003);
    exp_gnt.push_back(4'b0100);
    wait_gnt();
    chk("t3_we", 64'(s_we_o), 64'd1);
    chk("t3_wdat", 64'(s_dat_o), 64'hDEAD_0002);
    @(posedge clk); #1;
    s_rty_i = 1'b1; s_dat_i = 32'h0BAD_0002; stb[2] = 1'b0;
    exp_resp.push_back('{4'b0000, 4'b0100, 32'h0BAD_0002});
    @(posedge clk); #1;
    s_rty_i = 1'b0; s_dat_i = 32'h0; stb[2] = 1'b1;
    @(negedge clk);
    chk("t3_gnt_held", 64'(gnt_o), 64'h4);
    chk("t3_restrobe", 64'(s_stb_o), 64'd1);
    @(posedge clk); #1;
    s_ack_i = 1'b1; s_dat_i = 32'h55AA_0002;
    exp_resp.push_back('{4'b0100, 4'b0000, 32'h55AA_0002});
    set_req(2, 1'b0, 32'h0); we[2] = 1'b0;
    exp_gnt.push_back(4'b1000);
    @(posedge clk); #1;
    s_ack_i = 1'b0; s_dat_i = 32'h0;
    wait_gnt();
    @(posedge clk); #1;
    s_ack_i = 1'b1; s_dat_i = 32'h55AA_0003;
    exp_resp.push_back('{4'b1000, 4'b0000, 32'h55AA_0003});
    set_req(3, 1'b0, 32'h0);
    @(posedge clk); #1;
    s_ack_i = 1'b0; s_dat_i = 32'h0;

    // Watchdog: no NIC response, TMO=15 gives 16 clocks of cyc
    set_req(1, 1'b1, 32'hC0DE_0001);
    exp_gnt.push_back(4'b0010);
    exp_err.push_back(4'b0010);
    wait_gnt();
    n = 0;
    while (s_cyc_o == 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("t4_cyc_clks", 64'(n), 64'd16);
    chk("t4_err", 64'(r_err_o), 64'h2);
    chk("t4_busy", 64'(busy_o), 64'd1);
    repeat (2) @(negedge clk);
    chk("t4_err_held", 64'({gnt_o, r_err_o}), 64'h22);
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h0);
    set_req(0, 1'b1, 32'h3000_0000);
    set_req(2, 1'b1, 32'h3000_0002);
    exp_gnt.push_back(4'b0100);
    @(negedge clk);
    chk("t4_err_drop", 64'(r_err_o), 64'd0);

    // Ack in the very clock the timer reaches TMO
    wait_gnt();
    repeat (15) @(posedge clk);
    #1;
    s_ack_i = 1'b1; s_dat_i = 32'hC011_1DE5;
    exp_resp.push_back('{4'b0100, 4'b0000, 32'hC011_1DE5});
    @(negedge clk);
    chk("t5_no_err", 64'(r_err_o), 64'd0);
    @(posedge clk); #1;
    s_ack_i = 1'b0; s_dat_i = 32'h0;
    @(negedge clk);
    chk("t5_stay_busy", 64'({s_cyc_o, r_err_o}), 64'h10);
    @(posedge clk); #1;
    set_req(2, 1'b0, 32'h0);
    exp_gnt.push_back(4'b0001);
    @(posedge clk);
    wait_gnt();

    // Mid-cycle reset with requester 0 busy; ptr would otherwise favour 3
    set_req(1, 1'b1, 32'h4000_0001);
    set_req(3, 1'b1, 32'h4000_0003);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_gnt", 64'(gnt_o), 64'd0);
    chk("t6_rst_cyc", 64'(s_cyc_o), 64'd0);
    chk("t6_rst_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1 rst_i = 1'b0;
    exp_gnt.push_back(4'b0001);
    wait_gnt();
    chk("t6_first_gnt", 64'(gnt_o), 64'h1);
    @(posedge clk); #1;
    s_ack_i = 1'b1; s_dat_i = 32'h0000_0600;
    exp_resp.push_back('{4'b0001, 4'b0000, 32'h0000_0600});
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h0);
    @(posedge clk); #1;
    s_ack_i = 1'b0; s_dat_i = 32'h0;
    repeat (4) @(negedge clk);
    chk("left_gnt", 64'(exp_gnt.size()), 64'd0);
    chk("left_resp", 64'(exp_resp.size()), 64'd0);
    chk("left_err", 64'(exp_err.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf68000_nic_arb.md
# rf68000_nic_arb

Round-robin arbiter that shares one NIC slave port among NREQ local bus masters, such as a CPU core, a DMA engine and a debug port. It sits between the local masters and the NIC slave interface. It grants the port to one master for the whole of that master's bus cycle and routes ack/retry/data back to the owner only. It inserts an idle cycle between owners so the NIC always sees a cycle termination. A watchdog aborts cycles that never complete.

## Interface
- NREQ, 4: number of requesters (2..8).
- TMO, 1023: watchdog limit in clocks without ack/rty; counter width is clog2(TMO+1).
- rst_i  in  1  synchronous active-high reset
- clk_i  in  1  clock; one clock domain; reset is synchronous and active-high.
- r_cyc_i, r_stb_i, r_we_i  in  NREQ each  per-requester cycle/strobe/write
- r_cti_i  in  NREQ×3  per-requester cycle type
- r_sel_i  in  NREQ×4  byte selects
- r_adr_i, r_dat_i  in  NREQ×32  address / write data
- r_ack_o, r_rty_o, r_err_o  out  NREQ each  per-requester ack / retry / watchdog error
- r_dat_o  out  32  read data, shared by all requesters
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to NIC slave
- s_cti_o  out  3  cycle type to NIC
- s_sel_o  out  4  byte selects to NIC
- s_adr_o, s_dat_o  out  32  address / write data to NIC
- s_ack_i, s_rty_i  in  1 each  from NIC
- s_dat_i  in  32  read data from NIC
- gnt_o  out  NREQ  one-hot current grant; registered
- busy_o  out  1  state is not ST_IDLE

## Operation
- States: ST_IDLE, ST_BUSY, ST_ERR, ST_GAP.
- ST_IDLE:
  - Requesting set is `r_cyc_i & r_stb_i`.
  - If the set is non-empty, the arbiter picks the first requester at or after `ptr`, searching upward with wrap-around.
  - It loads `gnt_o` one-hot, clears the timer and moves to ST_BUSY.
- ST_BUSY:
  - s_* outputs are a combinational mux of the granted requester's r_* inputs.
  - s_ack_i / s_rty_i are routed to the owner's r_ack_o / r_rty_o; all other requesters see 0.
  - `r_dat_o = s_dat_i`.
  - Timer increments each clock and clears on any s_ack_i or s_rty_i.
  - When the owner drops r_cyc_i: ptr ← owner+1 (mod NREQ), gnt_o ← 0, state moves to ST_GAP.
  - When the timer reaches TMO and the owner still holds cyc: state moves to ST_ERR.
- ST_ERR:
  - s_cyc_o and s_stb_o are forced to 0; gnt_o is held.
  - r_err_o[owner] = 1 while the owner holds cyc.
  - When the owner drops cyc: ptr ← owner+1, gnt_o ← 0, state moves to ST_GAP.
- ST_GAP:
  - All s_* outputs are 0 for exactly one clock, then state moves to ST_IDLE.
- A retry does not release the grant. The owner keeps the port until it drops cyc and may re-strobe within the same cycle.
- Burst cycles (cti 001/111) hold the grant across beats until cyc drops.
- When no requester is granted, every s_* output is 0.

## Timing
- Reset values:
  - gnt_o=0, ptr=0, timer=0, state=ST_IDLE.
  - All s_* outputs = 0; r_ack_o, r_rty_o, r_err_o = 0; busy_o=0.
- Grant latency:
  - A request present at clock edge t loads the grant at t.
  - s_cyc_o is high in the cycle after t, which is 1 clock from request to NIC visibility.
- The ack/rty/dat return path is purely combinational; it adds 0 clocks.
- Minimum turnaround between owners is 2 clocks: 1 clock ST_GAP plus 1 clock in ST_IDLE.
- Simultaneous requests are resolved by ptr order only; there is no fixed priority.
- If the owner drops cyc in the same clock as s_ack_i: the ack is passed through, then the release proceeds normally.
- If the timer reaches TMO in the same clock as an s_ack_i or s_rty_i: the response wins, the timer clears, and the arbiter stays in ST_BUSY.
- Reset in any state returns the block to reset values at the next edge, with all s_* outputs low from that edge.
- A requester that raises cyc while another owns the port waits, and sees no ack/rty/err until it is granted.

## Test plan
- Single requester:
  - r_cyc_i[1]=1 with a read to 0xC0100010.
  - Required: gnt_o=0010 after 1 clk; s_adr_o=0xC0100010; an s_ack_i with s_dat_i=0x12345678 gives r_ack_o[1]=1 and r_dat_o=0x12345678.
  - After requester 1 drops cyc: 1 gap clock with s_cyc_o=0.
- Round-robin fairness:
  - Requesters 0–3 all request continuously, each cycle acked after 2 clks.
  - Required: grant order 0,1,2,3,0; no requester is granted twice before the others are served.
- Retry hold:
  - Owner 2 gets s_rty_i, then re-strobes without dropping cyc.
  - Required: gnt_o stays 0100; r_rty_o[2] pulses; no other requester is granted.
- Watchdog:
  - TMO=15; no ack from the NIC.
  - Required: s_cyc_o falls after 16 clks; r_err_o[owner]=1 until the owner drops cyc; ptr advances.
- Collision on a boundary:
  - Timer reaches TMO in the same clock as s_ack_i.
  - Required: no err; ack is delivered.
- Mid-cycle reset:
  - rst_i asserted in ST_BUSY.
  - Required: next clk gnt_o=0, s_cyc_o=0, ptr=0; the arbiter then grants requester 0 first.
